param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo.sv | 139 +++++++++++++
 tb/tb_param_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// Single-clock parameterised FIFO with registered or first-word-fall-through read data,
// registered occupancy flags and sticky overflow/underflow error flags.
module param_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     write_en,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     read_en,
  output logic [WIDTH-1:0]         read_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [CW-1:0] AfCnt    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeCnt    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic rd_acc;
  logic wr_acc;

  // A read frees a slot at the same edge, so a full FIFO still accepts a paired write.
  always_comb begin
    rd_acc = !flush && read_en && !empty_q;
    wr_acc = !flush && write_en && (!full_q || rd_acc);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    rdata_d  = rdata_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (write_en && full_q && !rd_acc) ovf_d = 1'b1;
      if (read_en && empty_q)            unf_d = 1'b1;

      if (FWFT == 0) begin
        if (rd_acc) rdata_d = mem_q[rd_ptr_q];
      end else if (count_d != '0) begin
        // The next head is the word being written this edge when nothing older remains.
        if (wr_acc && (rd_ptr_d == wr_ptr_q)) rdata_d = write_data;
        else                                  rdata_d = mem_q[rd_ptr_d];
      end
    end

    full_d   = (count_d == DepthCnt);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AfCnt);
    aempty_d = (count_d <= AeCnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= write_data;
  end

  always_comb begin
    read_data    = rdata_q;
    full         = full_q;
    empty        = empty_q;
    almost_full  = afull_q;
    almost_empty = aempty_q;
    count        = count_q;
    overflow     = ovf_q;
    underflow    = unf_q;
  end

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench: one registered-read and one FWFT instance share stimulus and are
// checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_param_fifo;
  localparam int D  = 16;
  localparam int AF = D - 2;
  localparam int AE = 2;

  logic       clk = 1'b0;
  logic       reset, flush, write_en, read_en;
  logic [7:0] write_data;

  logic [7:0] rd0, rd1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] cnt0, cnt1;

  always #5 clk = ~clk;

  param_fifo #(.WIDTH(8), .DEPTH(D), .FWFT(0)) u_reg (
    .clk(clk), .reset(reset), .flush(flush), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(rd0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
  );

  param_fifo #(.WIDTH(8), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .flush(flush), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(rd1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];    // reference contents, oldest first
  logic [7:0] exp0[$];  // registered-read words due on the next monitor sample
  bit         m_ovf, m_unf;
  logic [7:0] last0, head1;
  bit         mon_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input string tag, input logic [4:0] c, input logic f, input logic e,
                         input logic af, input logic ae, input logic ov, input logic un);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(c), n);
    chk({tag, ".full"}, 32'(f), 32'(n == D));
    chk({tag, ".empty"}, 32'(e), 32'(n == 0));
    chk({tag, ".almost_full"}, 32'(af), 32'(n >= AF));
    chk({tag, ".almost_empty"}, 32'(ae), 32'(n <= AE));
    chk({tag, ".overflow"}, 32'(ov), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(un), 32'(m_unf));
  endtask

  task automatic model_reset();
    mq.delete();
    exp0.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    last0 = 8'h00;
    head1 = 8'h00;
  endtask

  // Monitor: registered-read output is due one sample after a read was pushed.
  always @(negedge clk) begin
    if (mon_en) begin
      chk_dut("reg", cnt0, full0, empty0, af0, ae0, ovf0, unf0);
      chk_dut("fwft", cnt1, full1, empty1, af1, ae1, ovf1, unf1);
      if (exp0.size() > 0) last0 = exp0.pop_front();
      chk("reg.read_data", 32'(rd0), 32'(last0));
      chk("fwft.read_data", 32'(rd1), 32'(head1));
    end
  end

  // Drive one cycle, then advance the reference model by the rules of that edge.
  task automatic cyc(input bit we, input logic [7:0] wd, input bit re, input bit fl);
    bit racc, wacc;
    write_en   = we;
    write_data = wd;
    read_en    = re;
    flush      = fl;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      racc = re && (mq.size() > 0);
      wacc = we && ((mq.size() < D) || racc);
      if (re && mq.size() == 0) m_unf = 1'b1;
      if (we && !wacc)          m_ovf = 1'b1;
      if (racc) exp0.push_back(mq.pop_front());
      if (wacc) mq.push_back(wd);
      if (mq.size() > 0) head1 = mq[0];
    end
  endtask

  initial begin
    bit we, re, fl;
    int pct;
    reset      = 1'b0;
    flush      = 1'b0;
    write_en   = 1'b0;
    read_en    = 1'b0;
    write_data = 8'h00;
    mon_en     = 1'b0;
    model_reset();

    #12;
    chk("rst.count", 32'(cnt0), 0);
    chk("rst.empty", 32'(empty0), 1);
    chk("rst.full", 32'(full0), 0);
    chk("rst.almost_empty", 32'(ae0), 1);
    chk("rst.almost_full", 32'(af0), 0);
    chk("rst.read_data_reg", 32'(rd0), 0);
    chk("rst.read_data_fwft", 32'(rd1), 0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Fill to full, then drain in order.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill.full", 32'(full0), 1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drain.empty", 32'(empty0), 1);

    // Interleaved pairs walk the pointers around the ring more than twice.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Simultaneous read/write at full, then a dropped write.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("full_rw.count", 32'(cnt0), 16);
    cyc(1'b1, 8'h88, 1'b0, 1'b0);
    chk("drop.overflow", 32'(ovf0), 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drop.last_word", 32'(rd0), 32'h77);
    chk("drop.overflow_sticky", 32'(ovf0), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Underflow on empty, cleared by flush.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_rd.underflow", 32'(unf0), 1);
    chk("empty_rd.read_data", 32'(rd0), 32'h77);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush.underflow", 32'(unf0), 0);
    chk("flush.count", 32'(cnt0), 0);

    // FWFT presentation of a single word.
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("fwft.first_word", 32'(rd1), 32'h5A);
    chk("fwft.not_empty", 32'(empty1), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft.popped_empty", 32'(empty1), 1);
    chk("fwft.hold", 32'(rd1), 32'h5A);

    // Asynchronous reset mid-operation.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async.count", 32'(cnt0), 0);
    chk("async.empty", 32'(empty0), 1);
    chk("async.full", 32'(full0), 0);
    chk("async.almost_empty", 32'(ae0), 1);
    chk("async.underflow", 32'(unf0), 0);
    chk("async.read_data_reg", 32'(rd0), 0);
    chk("async.read_data_fwft", 32'(rd1), 0);
    #2;
    reset = 1'b1;
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("async.after_release", 32'(rd0), 32'h33);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 800; i++) begin
      pct = ((i / 100) % 2 == 0) ? 75 : 30;
      we  = ($urandom_range(99) < pct);
      re  = ($urandom_range(99) < (100 - pct));
      fl  = ($urandom_range(199) == 0);
      cyc(we, 8'($urandom_range(255)), re, fl);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
